ccc_dyncfg_ctrl: RTL
====================

# ccc_dyncfg_ctrl

Dynamic-reconfiguration sequencer for the MSS clock conditioning circuit (CCC/PLL). Accepts a full configuration word from a fabric requester over a request/acknowledge handshake. Shifts the word serially into the CCC dynamic-configuration register, issues the update strobe, then supervises PLL lock with a timeout. After a successful reconfiguration it keeps monitoring lock and reports loss. It sits in the fabric beside the MSS_CCC wrapper and owns its SCLK/SDIN/SSHIFT/SUPDATE/MODE pins.

## Interface
- CFG_WIDTH, 81, bits in the CCC dynamic-configuration shift register.
- SCLK_DIV, 4, FAB_CLK cycles per SCLK half-period; legal range ≥1.
- LOCK_TIMEOUT, 65535, FAB_CLK cycles allowed for lock after the update strobe; legal range ≥1.
- FAB_CLK  in  1  single clock for all logic.
- M2F_RESET_N  in  1  reset, asynchronous assert, active-low.
- CFG_REQ  in  1  requester holds high until CFG_ACK.
- CFG_WORD  in  CFG_WIDTH  configuration word; sampled on the accept cycle only.
- CFG_ACK  out  1  one-cycle pulse when the request is accepted.
- CFG_BUSY  out  1  high from accept until DONE/ERROR exit.
- CFG_DONE  out  1  one-cycle pulse: lock achieved.
- CFG_ERR  out  1  sticky lock-timeout flag; cleared on next accept.
- PLL_LOCK  in  1  asynchronous CCC lock; double-flop synchronised internally.
- CCC_MODE  out  1  1 = dynamic configuration selected; set at first accept, held thereafter.
- CCC_SCLK, CCC_SDIN, CCC_SSHIFT, CCC_SUPDATE  out  1 each  CCC serial config pins.
- LOCK_OK  out  1  synchronised lock, gated high only in state IDLE after a successful DONE.
- LOCK_LOST  out  1  sticky: synchronised lock fell while LOCK_OK was valid; cleared on accept.

## Operation
- Reset values: all outputs 0, state IDLE, shift register 0.
- States: IDLE → SHIFT → UPDATE → WAIT_LOCK → (DONE | ERROR) → IDLE.
- IDLE: on CFG_REQ=1 the block latches CFG_WORD, pulses CFG_ACK, clears CFG_ERR and LOCK_LOST, sets CFG_BUSY and CCC_MODE, and enters SHIFT.
- While busy, CFG_REQ is ignored. A request still high on return to IDLE is accepted one cycle later.
- SHIFT: data is sent LSB first, CFG_WIDTH SCLK periods, with CCC_SSHIFT=1 throughout.
  - SDIN is updated on the cycle SCLK falls; SCLK low first.
  - Bit counter width is clog2(CFG_WIDTH+1).
- UPDATE: SSHIFT=0 and SCLK=0. CCC_SUPDATE is high for 2·SCLK_DIV cycles, then the block enters WAIT_LOCK.
- WAIT_LOCK: the timeout counter loads LOCK_TIMEOUT and decrements each cycle.
  - Synchronised lock = 1 → DONE.
  - Counter reaching 0 → ERROR. If lock and counter-zero occur in the same cycle, DONE wins.
- DONE: pulses CFG_DONE, sets the internal lock_valid flag, returns to IDLE. ERROR: sets CFG_ERR, clears lock_valid, returns to IDLE. Both are one cycle, and CFG_BUSY drops on that cycle.
- lock_valid is cleared on accept.
- LOCK_LOST is set when lock_valid=1 and synchronised lock=0.
- Reset mid-operation forces SCLK/SSHIFT/SUPDATE low immediately and abandons the transfer. The CCC keeps its previous configuration, since no SUPDATE was issued.

## Timing
- Accept-to-first-SCLK-rise: 1 + SCLK_DIV cycles.
- SHIFT duration: CFG_WIDTH·2·SCLK_DIV cycles.
- Defaults give 648 SHIFT cycles and 8 UPDATE cycles.
- SDIN is stable ≥SCLK_DIV cycles on each side of the SCLK rising edge.
- The SSHIFT fall occurs ≥SCLK_DIV cycles after the last SCLK rise.
- Lock path latency is 2 cycles of synchroniser plus 1 state cycle to CFG_DONE.
- All pin outputs are registered; no combinational input→output paths.

## Structure
- Package ccc_cfg_pkg holds the state enum, the default CFG_WIDTH, and named constants for the CCC word field positions (FINDIV, FBDIV, OADIV, OBDIV, OCDIV, OAMUX/OBMUX/OCMUX, FBSEL, XDLYSEL) for requesters to build words.
- One sub-module: ccc_sclk_gen, a SCLK_DIV prescaler producing the SCLK level plus rise/fall strobes, enabled only in SHIFT.
- The lock synchroniser stays inline.

## Test plan
- Default params, CFG_WORD=81'h1_0000_0000_0000_0000_0001, PLL_LOCK rises 100 cycles after the SUPDATE fall.
  - Expect: serial capture on SCLK rises equals the word, LSB first.
  - Expect: 81 SCLK rises, one 8-cycle SUPDATE, CFG_DONE pulse, LOCK_OK=1.
- PLL_LOCK held 0, LOCK_TIMEOUT=50 → CFG_ERR=1 exactly 50 cycles after WAIT_LOCK entry; CFG_DONE never pulses; LOCK_OK=0.
- After a successful DONE, drop PLL_LOCK for 1 cycle → LOCK_LOST=1 sticky and LOCK_OK=0. The next accept clears both.
- CFG_REQ toggled and CFG_WORD changed during SHIFT → no extra ACK and shifted data unchanged. A REQ held through DONE yields a second ACK one cycle after return to IDLE.
- Assert M2F_RESET_N=0 at bit 40 → all outputs 0 in the same cycle with no SUPDATE. After release a new request completes normally.
- SCLK_DIV=1, CFG_WIDTH=8, word 8'hA5 → SCLK period 2 cycles and SDIN sequence 1,0,1,0,0,1,0,1.

Source files
------------

// File: rtl/ccc_cfg_pkg.sv
// ccc_cfg_pkg
//   Shared types and constants for the CCC dynamic-configuration sequencer.
//   Holds the sequencer state enum, the default width of the CCC
//   dynamic-configuration shift register, and the LSB/width of each field in
//   the configuration word so fabric requesters can assemble words by name.
package ccc_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_UPDATE,
    ST_WAIT_LOCK,
    ST_DONE,
    ST_ERROR
  } ccc_state_e;

  localparam int CCC_CFG_WIDTH = 81;

  // Field positions inside the configuration word (bit 0 is shifted first).
  localparam int FINDIV_LSB  = 0;   localparam int FINDIV_W  = 7;
  localparam int FBDIV_LSB   = 7;   localparam int FBDIV_W   = 7;
  localparam int OADIV_LSB   = 14;  localparam int OADIV_W   = 5;
  localparam int OBDIV_LSB   = 19;  localparam int OBDIV_W   = 5;
  localparam int OCDIV_LSB   = 24;  localparam int OCDIV_W   = 5;
  localparam int OAMUX_LSB   = 29;  localparam int OAMUX_W   = 3;
  localparam int OBMUX_LSB   = 32;  localparam int OBMUX_W   = 3;
  localparam int OCMUX_LSB   = 35;  localparam int OCMUX_W   = 3;
  localparam int FBSEL_LSB   = 38;  localparam int FBSEL_W   = 2;
  localparam int XDLYSEL_LSB = 45;  localparam int XDLYSEL_W = 1;

endpackage

// File: rtl/ccc_sclk_gen.sv
// ccc_sclk_gen
//   SCLK prescaler for the CCC serial configuration port.
//   SCLK starts low when enabled and toggles every SCLK_DIV cycles.
//   rise_stb / fall_stb are high in the cycle before SCLK goes high / low,
//   so the controller can act on the same clock edge that moves SCLK.
// Ports
//   clk_sys   in   fabric clock
//   rst_b     in   asynchronous active-low reset
//   en        in   run the prescaler; when low SCLK is held low and reloaded
//   sclk      out  registered SCLK level
//   rise_stb  out  SCLK rises on the next edge
//   fall_stb  out  SCLK falls on the next edge
module ccc_sclk_gen #(
  parameter int SCLK_DIV = 4
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CNT_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SCLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             half_end;

  assign half_end = en && (cnt_q == '0);
  assign rise_stb = half_end && !sclk;
  assign fall_stb = half_end && sclk;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q <= CNT_LOAD;
      sclk  <= 1'b0;
    end else if (!en) begin
      cnt_q <= CNT_LOAD;
      sclk  <= 1'b0;
    end else if (half_end) begin
      cnt_q <= CNT_LOAD;
      sclk  <= ~sclk;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/ccc_dyncfg_ctrl.sv
// ccc_dyncfg_ctrl
//   Dynamic-reconfiguration sequencer for the MSS CCC/PLL. Accepts a config
//   word over CFG_REQ/CFG_ACK, shifts it LSB first into the CCC, strobes
//   SUPDATE, then waits for PLL lock with a timeout and afterwards watches
//   for loss of lock.
// Ports
//   FAB_CLK, M2F_RESET_N          clock, async active-low reset
//   CFG_REQ, CFG_WORD, CFG_ACK    request handshake and word
//   CFG_BUSY, CFG_DONE, CFG_ERR   status (busy level, done pulse, sticky timeout)
//   PLL_LOCK                      asynchronous lock from the CCC
//   CCC_MODE, CCC_SCLK, CCC_SDIN, CCC_SSHIFT, CCC_SUPDATE   CCC config pins
//   LOCK_OK, LOCK_LOST            lock status after a successful reconfiguration
//
// state      | meaning
// -----------+------------------------------------------------------
// IDLE       | waiting for CFG_REQ; lock monitored if last run succeeded
// SHIFT      | serialising the word, SSHIFT high
// UPDATE     | SUPDATE high for 2*SCLK_DIV cycles
// WAIT_LOCK  | waiting for synchronised lock, timeout counting down
// DONE       | one cycle, lock achieved
// ERROR      | one cycle, lock timeout
module ccc_dyncfg_ctrl
  import ccc_cfg_pkg::*;
#(
  parameter int CFG_WIDTH    = CCC_CFG_WIDTH,
  parameter int SCLK_DIV     = 4,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                 FAB_CLK,
  input  logic                 M2F_RESET_N,
  input  logic                 CFG_REQ,
  input  logic [CFG_WIDTH-1:0] CFG_WORD,
  output logic                 CFG_ACK,
  output logic                 CFG_BUSY,
  output logic                 CFG_DONE,
  output logic                 CFG_ERR,
  input  logic                 PLL_LOCK,
  output logic                 CCC_MODE,
  output logic                 CCC_SCLK,
  output logic                 CCC_SDIN,
  output logic                 CCC_SSHIFT,
  output logic                 CCC_SUPDATE,
  output logic                 LOCK_OK,
  output logic                 LOCK_LOST
);

  localparam int BIT_W   = $clog2(CFG_WIDTH + 1);
  localparam int TMR_MAX = (LOCK_TIMEOUT > 2 * SCLK_DIV) ? LOCK_TIMEOUT : 2 * SCLK_DIV;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_WIDTH);
  localparam logic [TMR_W-1:0] UPD_LOAD = TMR_W'(2 * SCLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(LOCK_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  ccc_state_e           state_q, state_n;
  logic [CFG_WIDTH-1:0] shift_q, shift_n;
  logic [BIT_W-1:0]     bit_q, bit_n;
  logic [TMR_W-1:0]     tmr_q, tmr_n;
  logic                 lock_valid_q, lock_valid_n;
  logic                 lock_meta, lock_s;
  logic                 accept, busy_n, err_n, mode_n, lost_n, lock_ok_n;
  logic                 sclk_rise, sclk_fall;

  ccc_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
    .clk_sys  (FAB_CLK),
    .rst_b    (M2F_RESET_N),
    .en       (state_q == ST_SHIFT),
    .sclk     (CCC_SCLK),
    .rise_stb (sclk_rise),
    .fall_stb (sclk_fall)
  );

  // Bit 0 of the shift register is the SDIN flop; it moves on SCLK falls.
  assign CCC_SDIN = shift_q[0];

  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= PLL_LOCK;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    state_n      = state_q;
    shift_n      = shift_q;
    bit_n        = bit_q;
    tmr_n        = tmr_q;
    lock_valid_n = lock_valid_q;
    err_n        = CFG_ERR;
    mode_n       = CCC_MODE;
    lost_n       = LOCK_LOST;
    accept       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CFG_REQ) begin
          accept       = 1'b1;
          state_n      = ST_SHIFT;
          shift_n      = CFG_WORD;
          bit_n        = '0;
          err_n        = 1'b0;
          lost_n       = 1'b0;
          lock_valid_n = 1'b0;
          mode_n       = 1'b1;
        end
      end
      ST_SHIFT: begin
        // Rises are counted; the fall after the last rise ends the shift.
        if (sclk_rise) bit_n = bit_q + 1'b1;
        if (sclk_fall) begin
          shift_n = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_n = ST_UPDATE;
            tmr_n   = UPD_LOAD;
          end
        end
      end
      ST_UPDATE: begin
        if (tmr_q == '0) begin
          state_n = ST_WAIT_LOCK;
          tmr_n   = TMO_LOAD;
        end else begin
          tmr_n = tmr_q - 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        tmr_n = tmr_q - 1'b1;
        if (lock_s) begin
          state_n = ST_DONE;
        end else if (tmr_q == TMR_ONE) begin
          state_n = ST_ERROR;
          err_n   = 1'b1;
        end
      end
      ST_DONE: begin
        lock_valid_n = 1'b1;
        state_n      = ST_IDLE;
      end
      ST_ERROR: begin
        lock_valid_n = 1'b0;
        state_n      = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (lock_valid_q && !lock_s && !accept) lost_n = 1'b1;
    lock_ok_n = (state_q == ST_IDLE) && !accept && lock_valid_q && lock_s;
    busy_n    = (state_n == ST_SHIFT) || (state_n == ST_UPDATE) || (state_n == ST_WAIT_LOCK);
  end

  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_q        <= '0;
      tmr_q        <= '0;
      lock_valid_q <= 1'b0;
      CFG_ACK      <= 1'b0;
      CFG_BUSY     <= 1'b0;
      CFG_DONE     <= 1'b0;
      CFG_ERR      <= 1'b0;
      CCC_MODE     <= 1'b0;
      CCC_SSHIFT   <= 1'b0;
      CCC_SUPDATE  <= 1'b0;
      LOCK_OK      <= 1'b0;
      LOCK_LOST    <= 1'b0;
    end else begin
      state_q      <= state_n;
      shift_q      <= shift_n;
      bit_q        <= bit_n;
      tmr_q        <= tmr_n;
      lock_valid_q <= lock_valid_n;
      CFG_ACK      <= accept;
      CFG_BUSY     <= busy_n;
      CFG_DONE     <= (state_n == ST_DONE);
      CFG_ERR      <= err_n;
      CCC_MODE     <= mode_n;
      CCC_SSHIFT   <= (state_n == ST_SHIFT);
      CCC_SUPDATE  <= (state_n == ST_UPDATE);
      LOCK_OK      <= lock_ok_n;
      LOCK_LOST    <= lost_n;
    end
  end

endmodule
